// File: rtl/div_seq_pkg.sv
// Shared encodings and constants for the multi-cycle RV32M divide sequencer.
package div_seq_pkg;

   localparam int XLEN_C = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_NEG_A = 3'd1,
      ST_NEG_B = 3'd2,
      ST_ITER  = 3'd3,
      ST_FIX   = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam logic [XLEN_C-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [XLEN_C-1:0] DIV_OVF_Q  = 32'h8000_0000;

   // funct3[0] clear selects the signed flavour, funct3[1] set selects remainder.
   function automatic logic op_is_signed(op_e op);
      return ~op[0];
   endfunction

   function automatic logic op_is_rem(op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
interface div_seq_if
   import div_seq_pkg::*;
   ();

   logic              start;
   logic              kill;
   logic [1:0]        op;
   logic [XLEN_C-1:0] op1;
   logic [XLEN_C-1:0] op2;
   logic              busy;
   logic              done;
   logic [XLEN_C-1:0] result;

   modport master (
      output start, kill, op, op1, op2,
      input  busy, done, result
   );

   modport slave (
      input  start, kill, op, op1, op2,
      output busy, done, result
   );

endinterface

// File: rtl/div_seq_cla.sv
// 32-bit two-level carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module div_seq_cla (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);

   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] c;
   logic [7:0]  gg;
   logic [7:0]  gp;
   logic [8:0]  gc;

   always_comb begin
      g  = a_i & b_i;
      p  = a_i ^ b_i;
      gc = '0;
      c  = '0;
      gc[0] = cin_i;
      for (int k = 0; k < 8; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
      sum_o  = p ^ c;
      cout_o = gc[8];
   end

endmodule

// File: rtl/div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: one shared adder is reused for operand
// negation, 32 restoring trial subtractions and the final sign correction.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int ITERS = 32
) (
   input  logic      clk,
   input  logic      reset_n,
   div_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(ITERS);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [XLEN-1:0]   q_q, q_d;
   logic [XLEN-1:0]   r_q, r_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              a_neg_q, a_neg_d;
   logic              b_neg_q, b_neg_d;

   logic [XLEN-1:0]   add_a, add_b, add_sum;
   logic              add_cin, add_cout;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   fix_sel;
   logic              succ;
   logic              fix_neg;
   logic              req_signed;

   div_seq_cla u_add (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (add_cin),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_DIV;
         q_q      <= '0;
         r_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         q_q      <= q_d;
         r_q      <= r_d;
         b_q      <= b_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      q_d        = q_q;
      r_d        = r_q;
      b_d        = b_q;
      result_d   = result_q;
      cnt_d      = cnt_q;
      a_neg_d    = a_neg_q;
      b_neg_d    = b_neg_q;
      add_a      = '0;
      add_b      = '0;
      add_cin    = 1'b0;
      shifted    = {r_q[XLEN-2:0], q_q[XLEN-1]};
      succ       = 1'b0;
      fix_neg    = 1'b0;
      fix_sel    = q_q;
      req_signed = op_is_signed(op_e'(bus.op));

      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.kill) begin
               op_d    = op_e'(bus.op);
               q_d     = bus.op1;
               b_d     = bus.op2;
               r_d     = '0;
               cnt_d   = '0;
               a_neg_d = req_signed & bus.op1[XLEN-1];
               b_neg_d = req_signed & bus.op2[XLEN-1];
               if (bus.op2 == '0) begin
                  state_d  = ST_DONE;
                  result_d = op_is_rem(op_e'(bus.op)) ? bus.op1 : DIV_ZERO_Q;
               end else if (req_signed && bus.op1 == DIV_OVF_Q && bus.op2 == '1) begin
                  state_d  = ST_DONE;
                  result_d = op_is_rem(op_e'(bus.op)) ? '0 : DIV_OVF_Q;
               end else begin
                  state_d = ST_NEG_A;
               end
            end
         end
         ST_NEG_A: begin
            add_a   = ~q_q;
            add_cin = 1'b1;
            if (a_neg_q) q_d = add_sum;
            state_d = ST_NEG_B;
         end
         ST_NEG_B: begin
            add_a   = ~b_q;
            add_cin = 1'b1;
            if (b_neg_q) b_d = add_sum;
            state_d = ST_ITER;
         end
         ST_ITER: begin
            // The bit shifted out of R acts as bit 32 of the partial remainder.
            add_a   = shifted;
            add_b   = ~b_q;
            add_cin = 1'b1;
            succ    = r_q[XLEN-1] | add_cout;
            r_d     = succ ? add_sum : shifted;
            q_d     = {q_q[XLEN-2:0], succ};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS - 1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            fix_neg  = op_is_rem(op_q) ? a_neg_q : (a_neg_q ^ b_neg_q);
            fix_sel  = op_is_rem(op_q) ? r_q : q_q;
            add_a    = fix_neg ? ~fix_sel : fix_sel;
            add_cin  = fix_neg;
            result_d = add_sum;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A flush abandons whatever was in flight, including a pending result load.
      if (bus.kill) begin
         state_d  = ST_IDLE;
         result_d = result_q;
      end
   end

   assign bus.busy   = (state_q != ST_IDLE);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of expected results and latencies.
module tb_div_seq;
   import div_seq_pkg::*;

   typedef struct {
      string       tag;
      logic [31:0] val;
      int          ncyc;
      int          lat;
   } exp_t;

   logic   clk;
   logic   reset_n;
   int     cyc;
   int     n_assert;
   int     n_fail;
   int     last_n;
   exp_t   sb[$];

   div_seq_if bus ();

   div_seq #(.XLEN(32), .ITERS(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one start pulse; optionally record the expected outcome.
   task automatic do_start(input string tag, input op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp,
                           input int lat, input bit push);
      exp_t e;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op    = op;
      bus.op1   = a;
      bus.op2   = b;
      last_n    = cyc;
      if (push) begin
         e.tag = tag; e.val = exp; e.ncyc = cyc; e.lat = lat;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      bit   got;
      exp_t e;
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) got = 1'b1;
      end
      if (!got) begin
         check("done_timeout", 32'(got), 32'd1);
      end else if (sb.size() == 0) begin
         check("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check(e.tag, bus.result, e.val);
         check({e.tag, "_lat"}, 32'(cyc - e.ncyc), 32'(e.lat));
      end
   endtask

   task automatic run_op(input string tag, input op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      do_start(tag, op, a, b, exp, lat, 1'b1);
      wait_done();
   endtask

   initial begin
      int          seen;
      logic [31:0] held;
      cyc       = 0;
      n_assert  = 0;
      n_fail    = 0;
      last_n    = 0;
      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      bus.op    = 2'b00;
      bus.op1   = '0;
      bus.op2   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", bus.result, 32'd0);
      reset_n = 1'b1;

      // Normal path, unsigned and signed, with busy sampled during the run.
      do_start("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 36, 1'b1);
      @(negedge clk);
      check("busy_running", 32'(bus.busy), 32'd1);
      wait_done();
      @(negedge clk);
      check("busy_after_done", 32'(bus.busy), 32'd0);

      run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 36);
      run_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 36);
      run_op("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 36);
      run_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 36);
      run_op("rem_100_m7", OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 36);
      run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 36);
      run_op("remu_max_2", OP_REMU, 32'hFFFF_FFFF, 32'd2, 32'd1, 36);

      // Fast paths: divide by zero and signed overflow.
      run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
      run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      run_op("divu_nofast", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 36);

      // Kill during iteration 10.
      run_op("divu_1000_3", OP_DIVU, 32'd1000, 32'd3, 32'd333, 36);
      held = 32'd333;
      do_start("kill_op", OP_DIVU, 32'd77, 32'd5, 32'd0, 0, 1'b0);
      repeat (11) @(posedge clk);
      #1 bus.kill = 1'b1;
      @(posedge clk);
      #1 bus.kill = 1'b0;
      @(negedge clk);
      check("kill_busy", 32'(bus.busy), 32'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      check("kill_no_done", 32'(seen), 32'd0);
      check("kill_result", bus.result, held);

      // Kill and start together in IDLE: the start is dropped.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.kill = 1'b1;
      bus.op = OP_DIVU; bus.op1 = 32'd9; bus.op2 = 32'd0;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.kill = 1'b0;
      @(negedge clk);
      check("kill_start_busy", 32'(bus.busy), 32'd0);
      check("kill_start_done", 32'(bus.done), 32'd0);

      // Start re-pulsed while busy is ignored.
      do_start("divu_ignore2nd", OP_DIVU, 32'd100, 32'd7, 32'd14, 36, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.op = OP_DIV; bus.op1 = 32'd200; bus.op2 = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done();
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      check("ignored_no_2nd_done", 32'(seen), 32'd0);

      // Back-to-back: start in the cycle right after DONE.
      run_op("b2b_first", OP_REMU, 32'd1000, 32'd7, 32'd6, 36);
      run_op("b2b_second", OP_DIVU, 32'd1000, 32'd7, 32'd142, 36);

      // Asynchronous reset mid-ITER clears everything at once.
      do_start("rst_op", OP_DIVU, 32'd500, 32'd9, 32'd0, 0, 1'b0);
      repeat (8) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_result", bus.result, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      run_op("after_rst", OP_REMU, 32'd100, 32'd7, 32'd2, 36);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
